fib_stream_cipher_core: RTL
===========================

Name: fib_stream_cipher_core

Overview:
Parametrised successor to the fixed 16-bit Fibonacci stream-encryption top. It integrates the counter pair, dual Zeckendorf (binary-to-Fibonacci) conversion, keystream combining and bit-serial XOR encryption in one block. A valid/ready handshake on both the plaintext and ciphertext bit streams replaces the free-running out_c. A programmable word count sets when all_done is raised.

Parameters:
W, 16, binary width of the N and M counters and the key inputs.
FW, 23, Fibonacci digit count. Must satisfy F(FW+2) > 2^W-1; elaboration error otherwise.
M_STEP, 1, increment applied to M after each keystream word (mod 2^W). N always increments by 1.
NUM_WORDS, 0, number of keystream words before all_done. 0 means unlimited.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
en  in  1  global advance enable; low freezes conversion and input acceptance
start  in  1  load keys and begin; honoured only in IDLE
key_n  in  W  initial N value, sampled with start
key_m  in  W  initial M value, sampled with start
in_valid  in  1  plaintext bit valid
in_ready  out  1  plaintext bit accepted this cycle when in_valid & in_ready
in_bit  in  1  plaintext bit
out_valid  out  1  ciphertext bit valid
out_ready  in  1  downstream ready
out_bit  out  1  ciphertext bit
ks_word  out  FW  current keystream word
ks_valid  out  1  one-cycle pulse when ks_word updates
busy  out  1  high whenever state != IDLE
all_done  out  1  sticky; set after NUM_WORDS words fully emitted

Behaviour:
- Reset: state=IDLE; N, M, digit index, bit index and word counter = 0; ks_word=0; ks_valid=0; out_valid=0; out_bit=0; all_done=0; busy=0. Reset mid-operation aborts immediately and drops any pending out bit.
- Weights: digit i has weight F(i+2), i.e. 1,2,3,5,8,... Weight table is a constant FW-entry table of width W+1.
- IDLE: on start=1, load N=key_n and M=key_m, clear all_done, go to CONV with digit index=FW-1. start in any other state is ignored.
- CONV: one digit per cycle while en=1, for N and M in parallel. Greedy rule: if rem>=weight[i], digit i=1 and rem-=weight[i]; else digit i=0. rem is initialised from N or M on CONV entry. The result never has two adjacent ones. After digit 0:
  - ks_word = Nfib XOR rotl1(Mfib) over FW bits.
  - ks_valid pulses for 1 cycle.
  - bit index=0; go to EMIT.
  - Latency: ks_valid is high FW+1 cycles after the start sampling edge when en is held high.
- EMIT:
  - in_ready = en & (!out_valid | out_ready).
  - On acceptance: out_bit <= in_bit ^ ks_word[bit index] (LSB first), out_valid <= 1, bit index increments.
  - If out_valid & out_ready with no new acceptance, out_valid <= 0.
  - After bit FW-1 is accepted: N=N+1 and M=M+M_STEP (both wrap mod 2^W), word counter increments.
    - If NUM_WORDS!=0 and the counter reaches NUM_WORDS: set all_done and go to DRAIN.
    - Otherwise go to CONV.
- In CONV, DRAIN and IDLE, in_ready=0. A pending out bit still completes its handshake.
- DRAIN: go to IDLE once out_valid=0.
- en=0 freezes digit and bit progress; the output handshake continues.
- Back-pressure: out_bit and out_valid hold stable while out_valid & !out_ready.
- Wrap: N=2^W-1 increments to 0; conversion of 0 gives ks contribution 0.

Test Plan:
- Keys N=4, M=7, start, en=1 -> after FW+1 cycles ks_valid pulse and ks_word=0x000011 (Nfib=0b101, Mfib=0b1010 rotated to 0b10100).
- Key N=65535, M=0 -> ks_word=0x505204; check that no adjacent ones appear in any word across 1000 random keys against a reference greedy model.
- NUM_WORDS=2, 46 plaintext bits of all zeros, out_ready=1 -> ciphertext equals ks_word(4,7) then ks_word(5,8); all_done=1; busy falls once the last bit drains.
- out_ready held 0 for 10 cycles mid-word -> out_bit stable, in_ready=0, no bits lost or duplicated; XOR decrypt of the output restores the plaintext.
- rst asserted mid-CONV and mid-EMIT -> next cycle all outputs at reset values; a fresh start reproduces the first-scenario result.
- N=0xFFFF with M_STEP=3 and M=0xFFFE -> the next word uses N=0 and M=0x0001; start pulsed during EMIT is ignored.

Source files
------------

// File: rtl/fib_stream_cipher_core.sv
// Fibonacci keystream cipher: Zeckendorf-encodes an N/M counter pair one digit per cycle,
// combines the codes into a keystream word and XORs it bit-serially onto a handshaked plaintext stream.
module fib_stream_cipher_core #(
  parameter int unsigned W         = 16,
  parameter int unsigned FW        = 23,
  parameter int unsigned M_STEP    = 1,
  parameter int unsigned NUM_WORDS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [W-1:0]  key_n,
  input  logic [W-1:0]  key_m,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic [FW-1:0] ks_word,
  output logic          ks_valid,
  output logic          busy,
  output logic          all_done
);

  localparam int unsigned IW = (FW > 1) ? $clog2(FW) : 1;
  localparam logic [63:0] WMAX = (64'd1 << (W + 1)) - 64'd1;

  // F(i+2), saturated so the sequence cannot overflow for large FW
  function automatic logic [63:0] fib64(input int unsigned i);
    logic [63:0] a, b, t;
    a = 64'd1;
    b = 64'd2;
    for (int unsigned k = 0; k < i; k++) begin
      t = a + b;
      a = b;
      b = (t > 64'h4000_0000_0000_0000) ? 64'h4000_0000_0000_0000 : t;
    end
    return a;
  endfunction

  if (fib64(FW) <= ((64'd1 << W) - 64'd1)) begin : g_fw_too_small
    $error("FW too small: F(FW+2) must exceed 2^W-1");
  end

  logic [W:0] weight [FW];
  for (genvar gi = 0; gi < FW; gi++) begin : g_weight
    localparam logic [63:0] FV = fib64(gi);
    assign weight[gi] = (FV > WMAX) ? {(W + 1){1'b1}} : FV[W:0];
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_EMIT, S_DRAIN} state_t;

  state_t         state_q;
  logic [W-1:0]   n_q, m_q;
  logic [W-1:0]   rem_n_q, rem_m_q;
  logic [FW-1:0]  nfib_q, mfib_q;
  logic [IW-1:0]  idx_q, bit_q;
  logic [31:0]    wcnt_q;
  logic [FW-1:0]  ks_word_q;
  logic           ks_valid_q, out_valid_q, out_bit_q, all_done_q;

  logic [W:0]     w_cur;
  logic           dig_n_d, dig_m_d;
  logic [W-1:0]   rem_n_d, rem_m_d;
  logic [FW-1:0]  nfib_d, mfib_d, ks_d;
  logic           accept, last_bit;

  // Greedy Zeckendorf step for both counters against the current digit weight
  assign w_cur   = weight[idx_q];
  assign dig_n_d = ({1'b0, rem_n_q} >= w_cur);
  assign dig_m_d = ({1'b0, rem_m_q} >= w_cur);
  assign rem_n_d = dig_n_d ? (rem_n_q - w_cur[W-1:0]) : rem_n_q;
  assign rem_m_d = dig_m_d ? (rem_m_q - w_cur[W-1:0]) : rem_m_q;
  assign nfib_d  = nfib_q | (FW'(dig_n_d) << idx_q);
  assign mfib_d  = mfib_q | (FW'(dig_m_d) << idx_q);
  assign ks_d    = nfib_d ^ {mfib_d[FW-2:0], mfib_d[FW-1]};

  assign in_ready = (state_q == S_EMIT) & en & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign last_bit = (bit_q == IW'(FW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      m_q         <= '0;
      rem_n_q     <= '0;
      rem_m_q     <= '0;
      nfib_q      <= '0;
      mfib_q      <= '0;
      idx_q       <= '0;
      bit_q       <= '0;
      wcnt_q      <= '0;
      ks_word_q   <= '0;
      ks_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      ks_valid_q <= 1'b0;

      if (accept) begin
        out_bit_q   <= in_bit ^ ks_word_q[bit_q];
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q        <= key_n;
            m_q        <= key_m;
            wcnt_q     <= '0;
            all_done_q <= 1'b0;
            idx_q      <= IW'(FW - 1);
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (en) begin
            rem_n_q <= n_q;
            rem_m_q <= m_q;
            nfib_q  <= '0;
            mfib_q  <= '0;
            idx_q   <= IW'(FW - 1);
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          if (en) begin
            rem_n_q <= rem_n_d;
            rem_m_q <= rem_m_d;
            nfib_q  <= nfib_d;
            mfib_q  <= mfib_d;
            if (idx_q == '0) begin
              ks_word_q  <= ks_d;
              ks_valid_q <= 1'b1;
              bit_q      <= '0;
              state_q    <= S_EMIT;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (accept) begin
            if (last_bit) begin
              n_q    <= n_q + 1'b1;
              m_q    <= m_q + W'(M_STEP);
              wcnt_q <= wcnt_q + 32'd1;
              if ((NUM_WORDS != 0) && (wcnt_q + 32'd1 == NUM_WORDS)) begin
                all_done_q <= 1'b1;
                state_q    <= S_DRAIN;
              end else begin
                state_q <= S_LOAD;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!out_valid_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign ks_word   = ks_word_q;
  assign ks_valid  = ks_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign all_done  = all_done_q;

endmodule
